regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file with write-to-read bypass and a per-register
//  busy scoreboard. Successor of the 2R/1W 16-bit core regfile. Sits in decode: read
//  ports feed operand fetch, write ports take writeback, scoreboard gives hazard status.
// PARAMETERS
//  XLEN      16  data width in bits
//  NREGS     32  number of architectural registers; power of 2, >=2; AW = $clog2(NREGS)
//  NRD       2   number of read ports, 1..4
//  NWR       2   number of write ports, 1..2
//  BYPASS    1   1 = a same-cycle write is forwarded to the reads; 0 = reads return stored value
//  ZERO_REG  1   1 = r0 is hardwired to zero; 0 = r0 is an ordinary register
// PORTS
//  clk       in   1          clock; all state updates on the rising edge
//  rst_n     in   1          synchronous reset, active low
//  rd_addr   in   NRD*AW     read addresses; port i is bits [i*AW +: AW]
//  rd_data   out  NRD*XLEN   read data, combinational from rd_addr
//  rd_busy   out  NRD        scoreboard busy bit of each read address
//  wr_en     in   NWR        write enables
//  wr_addr   in   NWR*AW     write addresses
//  wr_data   in   NWR*XLEN   write data
//  iss_en    in   1          issue: mark register iss_rd as having an outstanding producer
//  iss_rd    in   AW         destination register being issued
//  busy_vec  out  NREGS      full scoreboard state, bit n = register n busy
// BEHAVIOUR
//  - Reset: sampled rst_n=0 clears all registers to 0 and all busy bits to 0. Reset
//    overrides every same-cycle write and issue. rd_data=0, rd_busy=0 and busy_vec=0
//    from the first cycle after the reset edge.
//  - Write: wr_en[k] writes wr_data[k] to wr_addr[k] on the edge; write latency 1.
//  - Write conflict: when two write ports hit the same address, the higher port index wins.
//  - Read: rd_data[i] = regfile[rd_addr[i]], combinational with zero latency.
//  - BYPASS=1: if any enabled write targets rd_addr[i] this cycle, rd_data[i] returns the
//    winning wr_data. BYPASS=0: rd_data[i] returns the old value; new value visible next cycle.
//  - ZERO_REG=1: writes to r0 are dropped, reads of r0 return 0 (never bypassed), and r0
//    busy is never set (iss_rd=0 ignored).
//  - Scoreboard update per register n on the edge, in priority order:
//    1. iss_en && iss_rd==n -> busy[n] <= 1 (a new producer overrides a same-cycle retire)
//    2. else any wr_en[k] && wr_addr[k]==n -> busy[n] <= 0
//    3. else hold.
//  - rd_busy[i] = busy[rd_addr[i]]. With BYPASS=1, rd_busy[i] is also forced to 0 when
//    an enabled write to rd_addr[i] is present this cycle, because the data is forwarded.
//  - Issuing to an already-busy register keeps busy=1 (WAW; the pipeline orders the writes).
//  - No X propagation: unwritten registers read 0 after reset. Addresses >= NREGS cannot
//    occur because NREGS is a power of 2.
// STRUCTURE
//  - regfile_pkg: AW_F(n) helper, reg_idx_t/xdata_t typedefs, R_ZERO constant.
//  - Sub-module regfile_scoreboard: NREGS busy flops, issue/retire logic, rd_busy muxes.
//  - Top level: storage array, write-port priority resolve, bypass muxes, generate loops
//    over NRD and NWR.
// TESTING
//  1. Reset: write r5=0x1234, hold rst_n=0 for 1 cycle -> r5 reads 0x0000; busy_vec=0.
//  2. Bypass: BYPASS=1, wr r3=0xBEEF and rd_addr0=3 in the same cycle -> rd_data0=0xBEEF
//     that cycle. BYPASS=0 -> old value that cycle, 0xBEEF the next cycle.
//  3. Port conflict: wr0 r7=0x1111 and wr1 r7=0x2222 in the same cycle -> r7=0x2222.
//  4. Zero reg: wr r0=0xFFFF and iss_rd=0 -> r0 reads 0, busy_vec[0]=0; ZERO_REG=0 -> r0=0xFFFF.
//  5. Scoreboard: iss r4 -> busy[4]=1 next cycle; wr r4 -> 0. Issue r4 and write r4 in
//     the same cycle -> busy[4] stays 1.
//  6. Sweep NRD=4/NWR=1/NREGS=16/XLEN=32: random writes vs a reference model, all read
//     ports compared every cycle, reset asserted mid-stream.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 16;
    localparam int NREGS_DEF = 32;

    // Architectural zero register index.
    localparam int R_ZERO = 0;

    // Address width for an n-entry file; never less than one bit.
    function automatic int AW_F(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [AW_F(NREGS_DEF)-1:0] reg_idx_t;
    typedef logic [XLEN_DEF-1:0]        xdata_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one flop per register, set on issue, cleared on writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int NWR      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = AW_F(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    fwd,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    output logic [NRD-1:0]    rd_busy,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic             iss_ok;

    // r0 can never have a pending producer when it is hardwired to zero.
    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_rd == AW'(R_ZERO)));

    // Decode the issue into a set mask and every enabled writeback into a retire mask.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_ok) set_vec[iss_rd] = 1'b1;
        for (int k = 0; k < NWR; k++)
            if (wr_en[k]) clr_vec[wr_addr[k*AW +: AW]] = 1'b1;
    end

    // Busy flops: a new producer beats a same-cycle retire, retire beats hold.
    always_ff @(posedge clk) begin
        if (!rst_n) busy <= '0;
        else        busy <= set_vec | (busy & ~clr_vec);
    end

    // Per read port lookup; an operand being forwarded this cycle is not a hazard.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++)
            rd_busy[i] = busy[rd_addr[i*AW +: AW]] & ~fwd[i];
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = 16,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int NWR      = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = AW_F(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREGS-1:0]    busy_vec
);

    localparam logic HAS_ZERO = (ZERO_REG != 0);
    localparam logic HAS_BYP  = (BYPASS != 0);

    logic [XLEN-1:0] regs [NREGS];
    logic [NRD-1:0]  fwd;

    // Storage update; ports apply in ascending order so the highest enabled port wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NREGS; n++) regs[n] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (wr_en[k] && !(HAS_ZERO && wr_addr[k*AW +: AW] == AW'(R_ZERO)))
                    regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] hit_data;

        assign ra = rd_addr[i*AW +: AW];

        // Find the winning same-cycle write to this read address (later ports override).
        always_comb begin
            hit      = 1'b0;
            hit_data = '0;
            for (int k = 0; k < NWR; k++)
                if (wr_en[k] && wr_addr[k*AW +: AW] == ra) begin
                    hit      = 1'b1;
                    hit_data = wr_data[k*XLEN +: XLEN];
                end
        end

        assign fwd[i] = HAS_BYP && hit;

        // Hardwired r0 takes precedence over forwarding.
        assign rd_data[i*XLEN +: XLEN] = (HAS_ZERO && ra == AW'(R_ZERO)) ? '0 :
                                         fwd[i] ? hit_data : regs[ra];
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .fwd      (fwd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: three configurations against a behavioural model.
module tb_regfile_mp;

    localparam int AW  = 5;
    localparam int CAW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for dut_a (BYPASS=1, ZERO_REG=1) and dut_b (BYPASS=0, ZERO_REG=0)
    logic            rst_n;
    logic [2*AW-1:0] rd_addr;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [31:0]     wr_data;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic [31:0]     rd_data_a, rd_data_b;
    logic [1:0]      rd_busy_a, rd_busy_b;
    logic [31:0]     busy_vec_a, busy_vec_b;

    // Stimulus for dut_c (XLEN=32, NREGS=16, NRD=4, NWR=1)
    logic            c_rst_n;
    logic [15:0]     c_rd_addr;
    logic [0:0]      c_wr_en;
    logic [3:0]      c_wr_addr;
    logic [31:0]     c_wr_data;
    logic            c_iss_en;
    logic [3:0]      c_iss_rd;
    logic [127:0]    c_rd_data;
    logic [3:0]      c_rd_busy;
    logic [15:0]     c_busy_vec;

    int vectors     = 0;
    int miscompares = 0;

    regfile_mp #(.XLEN(16), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
        .busy_vec(busy_vec_a)
    );

    regfile_mp #(.XLEN(16), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
        .busy_vec(busy_vec_b)
    );

    regfile_mp #(.XLEN(32), .NREGS(16), .NRD(4), .NWR(1), .BYPASS(1), .ZERO_REG(1)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .iss_en(c_iss_en),
        .iss_rd(c_iss_rd), .busy_vec(c_busy_vec)
    );

    // Reference model: architectural state per DUT (index 0=a, 1=b, 2=c)
    logic [31:0] m_mem  [3][32];
    logic        m_busy [3][32];

    function automatic bit byp(int d); return d != 1; endfunction
    function automatic bit zr(int d);  return d != 1; endfunction

    function automatic bit m_we(int d, int k);
        if (d < 2) return wr_en[k];
        return (k == 0) && c_wr_en[0];
    endfunction

    function automatic int m_wa(int d, int k);
        if (d < 2) return int'(wr_addr[k*AW +: AW]);
        return int'(c_wr_addr);
    endfunction

    function automatic logic [31:0] m_wd(int d, int k);
        if (d < 2) return {16'h0, wr_data[k*16 +: 16]};
        return c_wr_data;
    endfunction

    // Value a read port should see right now.
    function automatic logic [31:0] m_read(int d, int ra);
        logic [31:0] v;
        if (zr(d) && ra == 0) return 32'h0;
        v = m_mem[d][ra];
        if (byp(d))
            for (int k = 0; k < 2; k++)
                if (m_we(d, k) && m_wa(d, k) == ra) v = m_wd(d, k);
        return v;
    endfunction

    // Busy flag a read port should see right now.
    function automatic logic m_rbusy(int d, int ra);
        if (byp(d))
            for (int k = 0; k < 2; k++)
                if (m_we(d, k) && m_wa(d, k) == ra) return 1'b0;
        return m_busy[d][ra];
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    function automatic void m_commit(int d);
        bit rst_now;
        bit iss;
        int ird;
        rst_now = (d < 2) ? !rst_n : !c_rst_n;
        iss     = (d < 2) ? iss_en : c_iss_en;
        ird     = (d < 2) ? int'(iss_rd) : int'(c_iss_rd);
        if (rst_now) begin
            for (int n = 0; n < 32; n++) begin
                m_mem[d][n]  = 32'h0;
                m_busy[d][n] = 1'b0;
            end
            return;
        end
        for (int k = 0; k < 2; k++)
            if (m_we(d, k)) begin
                if (!(zr(d) && m_wa(d, k) == 0)) m_mem[d][m_wa(d, k)] = m_wd(d, k);
                m_busy[d][m_wa(d, k)] = 1'b0;
            end
        if (iss && !(zr(d) && ird == 0)) m_busy[d][ird] = 1'b1;
    endfunction

    task automatic tick();
        for (int d = 0; d < 3; d++) m_commit(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_rd = '0;
        c_rst_n = 1'b1; c_rd_addr = '0; c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0;
        c_iss_en = 1'b0; c_iss_rd = '0;
    endtask

    task automatic do_reset();
        idle(); rst_n = 1'b0; c_rst_n = 1'b0; tick(); idle();
    endtask

    task automatic set_rd(int i, int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(int k, int a, logic [15:0] v);
        wr_en[k] = 1'b1;
        wr_addr[k*AW +: AW] = AW'(a);
        wr_data[k*16 +: 16] = v;
    endtask

    function automatic int pick(int n);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, n - 1));
        return int'($urandom_range(0, 7));
    endfunction

    task automatic test_reset();
        do_reset();
        set_wr(0, 5, 16'h1234); tick();
        idle(); set_rd(0, 5); #1;
        vectors++;
        if (rd_data_a[15:0] !== 16'h1234) begin miscompares++;
            $display("FAIL reset_pre_r5: got %h expected 1234", rd_data_a[15:0]); end
        // Reset must win over a same-cycle write and issue
        rst_n = 1'b0; c_rst_n = 1'b0; set_wr(1, 5, 16'h5555); iss_en = 1'b1; iss_rd = 5'd9;
        c_wr_en = 1'b1; c_wr_addr = 4'd2; c_wr_data = 32'hDEADBEEF; c_iss_en = 1'b1; c_iss_rd = 4'd2;
        tick();
        idle(); set_rd(0, 5); set_rd(1, 9); c_rd_addr[CAW +: CAW] = 4'd2; #1;
        vectors++;
        if (rd_data_a !== 32'h0) begin miscompares++;
            $display("FAIL reset_rd_a: got %h expected 0", rd_data_a); end
        vectors++;
        if (rd_data_b !== 32'h0) begin miscompares++;
            $display("FAIL reset_rd_b: got %h expected 0", rd_data_b); end
        vectors++;
        if (busy_vec_a !== 32'h0 || busy_vec_b !== 32'h0) begin miscompares++;
            $display("FAIL reset_busy_vec: got %h/%h expected 0", busy_vec_a, busy_vec_b); end
        vectors++;
        if (rd_busy_a !== 2'b00) begin miscompares++;
            $display("FAIL reset_rd_busy: got %b expected 00", rd_busy_a); end
        vectors++;
        if (c_rd_data !== 128'h0 || c_busy_vec !== 16'h0) begin miscompares++;
            $display("FAIL reset_c: got %h/%h expected 0", c_rd_data, c_busy_vec); end
    endtask

    task automatic test_bypass();
        do_reset();
        iss_en = 1'b1; iss_rd = 5'd3; tick();
        idle(); set_wr(0, 3, 16'hBEEF); set_rd(0, 3); #1;
        vectors++;
        if (rd_data_a[15:0] !== 16'hBEEF) begin miscompares++;
            $display("FAIL bypass_a_data: got %h expected beef", rd_data_a[15:0]); end
        vectors++;
        if (rd_data_b[15:0] !== 16'h0000) begin miscompares++;
            $display("FAIL nobypass_b_old: got %h expected 0000", rd_data_b[15:0]); end
        vectors++;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b1) begin miscompares++;
            $display("FAIL bypass_rd_busy: got a=%b b=%b expected a=0 b=1", rd_busy_a[0], rd_busy_b[0]); end
        tick();
        idle(); set_rd(0, 3); #1;
        vectors++;
        if (rd_data_b[15:0] !== 16'hBEEF || rd_data_a[15:0] !== 16'hBEEF) begin miscompares++;
            $display("FAIL bypass_next: got a=%h b=%h expected beef", rd_data_a[15:0], rd_data_b[15:0]); end
        vectors++;
        if (rd_busy_b[0] !== 1'b0) begin miscompares++;
            $display("FAIL bypass_retired: got %b expected 0", rd_busy_b[0]); end
    endtask

    task automatic test_conflict();
        do_reset();
        set_wr(0, 7, 16'h1111); set_wr(1, 7, 16'h2222); set_rd(1, 7); #1;
        vectors++;
        if (rd_data_a[31:16] !== 16'h2222) begin miscompares++;
            $display("FAIL conflict_bypass: got %h expected 2222", rd_data_a[31:16]); end
        tick();
        idle(); set_wr(0, 8, 16'h2222); set_wr(1, 8, 16'h1111); set_rd(0, 7); set_rd(1, 7); #1;
        vectors++;
        if (rd_data_a !== 32'h22222222 || rd_data_b !== 32'h22222222) begin miscompares++;
            $display("FAIL conflict_r7: got a=%h b=%h expected 22222222", rd_data_a, rd_data_b); end
        tick();
        idle(); set_rd(0, 8); #1;
        vectors++;
        if (rd_data_b[15:0] !== 16'h1111) begin miscompares++;
            $display("FAIL conflict_r8: got %h expected 1111", rd_data_b[15:0]); end
    endtask

    task automatic test_zero();
        do_reset();
        set_wr(0, 0, 16'hFFFF); iss_en = 1'b1; iss_rd = 5'd0; set_rd(0, 0); #1;
        vectors++;
        if (rd_data_a[15:0] !== 16'h0000 || rd_data_b[15:0] !== 16'h0000) begin miscompares++;
            $display("FAIL zero_same_cycle: got a=%h b=%h expected 0000", rd_data_a[15:0], rd_data_b[15:0]); end
        tick();
        idle(); set_rd(0, 0); #1;
        vectors++;
        if (rd_data_a[15:0] !== 16'h0000 || busy_vec_a[0] !== 1'b0) begin miscompares++;
            $display("FAIL zero_a: got data=%h busy=%b expected 0000/0", rd_data_a[15:0], busy_vec_a[0]); end
        vectors++;
        if (rd_data_b[15:0] !== 16'hFFFF || busy_vec_b[0] !== 1'b1) begin miscompares++;
            $display("FAIL zero_b_plain: got data=%h busy=%b expected ffff/1", rd_data_b[15:0], busy_vec_b[0]); end
    endtask

    task automatic test_scoreboard();
        do_reset();
        iss_en = 1'b1; iss_rd = 5'd4; tick();
        idle(); set_rd(1, 4); #1;
        vectors++;
        if (busy_vec_a[4] !== 1'b1 || rd_busy_a[1] !== 1'b1 || busy_vec_b[4] !== 1'b1) begin miscompares++;
            $display("FAIL sb_issue: got %b%b%b expected 111", busy_vec_a[4], rd_busy_a[1], busy_vec_b[4]); end
        set_wr(0, 4, 16'h0044); #1;
        vectors++;
        if (rd_busy_a[1] !== 1'b0 || rd_busy_b[1] !== 1'b1) begin miscompares++;
            $display("FAIL sb_fwd_busy: got a=%b b=%b expected a=0 b=1", rd_busy_a[1], rd_busy_b[1]); end
        tick();
        idle(); set_rd(1, 4); #1;
        vectors++;
        if (busy_vec_a[4] !== 1'b0 || rd_busy_a[1] !== 1'b0) begin miscompares++;
            $display("FAIL sb_retire: got %b%b expected 00", busy_vec_a[4], rd_busy_a[1]); end
        iss_en = 1'b1; iss_rd = 5'd4; set_wr(1, 4, 16'h0045); tick();
        idle(); #1;
        vectors++;
        if (busy_vec_a !== 32'h10 || busy_vec_b !== 32'h10) begin miscompares++;
            $display("FAIL sb_issue_beats_retire: got %h/%h expected 10", busy_vec_a, busy_vec_b); end
        iss_en = 1'b1; iss_rd = 5'd4; tick();
        idle(); #1;
        vectors++;
        if (busy_vec_a !== 32'h10) begin miscompares++;
            $display("FAIL sb_waw: got %h expected 10", busy_vec_a); end
    endtask

    task automatic test_random_ab();
        int          ra;
        logic [31:0] e;
        logic [31:0] ev;
        logic [15:0] g;
        logic        gb;
        logic [31:0] gv;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            idle();
            rst_n = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < 2; i++) set_rd(i, pick(32));
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 1) == 1) set_wr(k, pick(32), 16'($urandom));
            iss_en = ($urandom_range(0, 2) == 0);
            iss_rd = AW'(pick(32));
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 2; i++) begin
                    ra = int'(rd_addr[i*AW +: AW]);
                    e  = m_read(d, ra);
                    g  = (d == 0) ? rd_data_a[i*16 +: 16] : rd_data_b[i*16 +: 16];
                    vectors++;
                    if (g !== e[15:0]) begin miscompares++;
                        $display("FAIL rand_rd dut%0d port%0d r%0d cyc%0d: got %h expected %h", d, i, ra, cyc, g, e[15:0]); end
                    gb = (d == 0) ? rd_busy_a[i] : rd_busy_b[i];
                    vectors++;
                    if (gb !== m_rbusy(d, ra)) begin miscompares++;
                        $display("FAIL rand_busy dut%0d port%0d r%0d cyc%0d: got %b expected %b", d, i, ra, cyc, gb, m_rbusy(d, ra)); end
                end
                for (int n = 0; n < 32; n++) ev[n] = m_busy[d][n];
                gv = (d == 0) ? busy_vec_a : busy_vec_b;
                vectors++;
                if (gv !== ev) begin miscompares++;
                    $display("FAIL rand_busy_vec dut%0d cyc%0d: got %h expected %h", d, cyc, gv, ev); end
            end
            tick();
        end
    endtask

    task automatic test_sweep_c();
        int          ra;
        logic [31:0] e;
        logic [15:0] ev;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            idle();
            c_rst_n = (cyc != 150) && ($urandom_range(0, 59) != 0);
            for (int i = 0; i < 4; i++) c_rd_addr[i*CAW +: CAW] = CAW'(pick(16));
            c_wr_en   = 1'($urandom_range(0, 1));
            c_wr_addr = CAW'(pick(16));
            c_wr_data = $urandom;
            c_iss_en  = ($urandom_range(0, 2) == 0);
            c_iss_rd  = CAW'(pick(16));
            #1;
            for (int i = 0; i < 4; i++) begin
                ra = int'(c_rd_addr[i*CAW +: CAW]);
                e  = m_read(2, ra);
                vectors++;
                if (c_rd_data[i*32 +: 32] !== e) begin miscompares++;
                    $display("FAIL sweep_rd port%0d r%0d cyc%0d: got %h expected %h", i, ra, cyc, c_rd_data[i*32 +: 32], e); end
                vectors++;
                if (c_rd_busy[i] !== m_rbusy(2, ra)) begin miscompares++;
                    $display("FAIL sweep_busy port%0d r%0d cyc%0d: got %b expected %b", i, ra, cyc, c_rd_busy[i], m_rbusy(2, ra)); end
            end
            for (int n = 0; n < 16; n++) ev[n] = m_busy[2][n];
            vectors++;
            if (c_busy_vec !== ev) begin miscompares++;
                $display("FAIL sweep_busy_vec cyc%0d: got %h expected %h", cyc, c_busy_vec, ev); end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_conflict();
        test_zero();
        test_scoreboard();
        test_random_ab();
        test_sweep_c();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
